// File: rtl/linear_pkg.sv
// rtl/linear_pkg.sv - shared types and elaboration helpers for the linear output serializer
package linear_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns the beat count, or 0 when the vector does not split into whole beats.
  function automatic int calc_beats(input int out_feature, input int beat_elems);
    if (beat_elems <= 0) return 0;
    if ((out_feature % beat_elems) != 0) return 0;
    return out_feature / beat_elems;
  endfunction

endpackage

// File: rtl/beat_argmax_reduce.sv
// rtl/beat_argmax_reduce.sv - combinational (max value, slot) reduction over one beat
module beat_argmax_reduce #(
  parameter int pDATA_WIDTH = 8,
  parameter int pBEAT_ELEMS = 4,
  parameter int pSIGNED     = 1,
  parameter int pSLOT_W     = (pBEAT_ELEMS > 1) ? $clog2(pBEAT_ELEMS) : 1
) (
  input  logic [pDATA_WIDTH*pBEAT_ELEMS-1:0] in_elems,
  output logic [pDATA_WIDTH-1:0]             max_val,
  output logic [pSLOT_W-1:0]                 max_slot
);

  function automatic logic elem_gt(input logic [pDATA_WIDTH-1:0] a, input logic [pDATA_WIDTH-1:0] b);
    if (pSIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  logic [pDATA_WIDTH-1:0] w_elem;

  // Strict compare while scanning upward keeps the lowest slot on ties.
  always_comb begin
    max_val  = in_elems[pDATA_WIDTH-1:0];
    max_slot = '0;
    w_elem   = '0;
    for (int j = 1; j < pBEAT_ELEMS; j++) begin
      w_elem = in_elems[j*pDATA_WIDTH +: pDATA_WIDTH];
      if (elem_gt(w_elem, max_val)) begin
        max_val  = w_elem;
        max_slot = pSLOT_W'(j);
      end
    end
  end

endmodule

// File: rtl/linear_output_serializer.sv
// rtl/linear_output_serializer.sv - captures a PE output vector, streams it as beats, tracks argmax
module linear_output_serializer
  import linear_pkg::*;
#(
  parameter int pDATA_WIDTH  = 8,
  parameter int pOUT_FEATURE = 128,
  parameter int pBEAT_ELEMS  = 4,
  parameter int pSIGNED      = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  input  logic [pDATA_WIDTH*pOUT_FEATURE-1:0] in_data,
  output logic                                in_ready,
  output logic                                overrun,
  output logic [pDATA_WIDTH*pBEAT_ELEMS-1:0]  m_data,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic                                m_last,
  output logic [$clog2(pOUT_FEATURE)-1:0]     argmax_idx,
  output logic [pDATA_WIDTH-1:0]              argmax_val,
  output logic                                argmax_valid
);

  localparam int pBEATS     = calc_beats(pOUT_FEATURE, pBEAT_ELEMS);
  localparam int pIDX_W     = $clog2(pOUT_FEATURE);
  localparam int pBEAT_W    = (pBEATS > 1) ? $clog2(pBEATS) : 1;
  localparam int pSLOT_W    = (pBEAT_ELEMS > 1) ? $clog2(pBEAT_ELEMS) : 1;
  localparam int pBEAT_BITS = pDATA_WIDTH * pBEAT_ELEMS;

  if (pBEATS == 0) begin : g_bad_cfg
    $error("pOUT_FEATURE must be a positive multiple of pBEAT_ELEMS");
  end

  state_t                              r_state;
  logic [pDATA_WIDTH*pOUT_FEATURE-1:0] r_hold;
  logic [pBEAT_W-1:0]                  r_beat;
  logic [pDATA_WIDTH-1:0]              r_max_val;
  logic [pIDX_W-1:0]                   r_max_idx;
  logic                                r_in_ready;
  logic                                r_m_valid;
  logic                                r_m_last;
  logic                                r_argmax_valid;
  logic                                r_overrun;

  logic [pBEAT_BITS-1:0]  w_beat_data;
  logic [pDATA_WIDTH-1:0] w_red_val;
  logic [pSLOT_W-1:0]     w_red_slot;
  logic [pIDX_W-1:0]      w_cand_idx;
  logic                   w_last;

  function automatic logic elem_gt(input logic [pDATA_WIDTH-1:0] a, input logic [pDATA_WIDTH-1:0] b);
    if (pSIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  assign w_beat_data = r_hold[r_beat*pBEAT_BITS +: pBEAT_BITS];
  assign w_last      = (r_beat == pBEAT_W'(pBEATS - 1));
  assign w_cand_idx  = pIDX_W'(int'(r_beat) * pBEAT_ELEMS + int'(w_red_slot));

  beat_argmax_reduce #(
    .pDATA_WIDTH (pDATA_WIDTH),
    .pBEAT_ELEMS (pBEAT_ELEMS),
    .pSIGNED     (pSIGNED),
    .pSLOT_W     (pSLOT_W)
  ) u_reduce (
    .in_elems (w_beat_data),
    .max_val  (w_red_val),
    .max_slot (w_red_slot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_hold         <= '0;
      r_beat         <= '0;
      r_max_val      <= '0;
      r_max_idx      <= '0;
      r_in_ready     <= 1'b1;
      r_m_valid      <= 1'b0;
      r_m_last       <= 1'b0;
      r_argmax_valid <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      // A capture request outside IDLE is dropped; only the pulse records it.
      r_overrun <= in_valid && (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_hold     <= in_data;
            r_beat     <= '0;
            r_max_val  <= '0;
            r_max_idx  <= '0;
            r_in_ready <= 1'b0;
            r_m_valid  <= 1'b1;
            r_m_last   <= (pBEATS == 1);
            r_state    <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m_ready) begin
            if ((r_beat == '0) || elem_gt(w_red_val, r_max_val)) begin
              r_max_val <= w_red_val;
              r_max_idx <= w_cand_idx;
            end
            if (w_last) begin
              r_m_valid      <= 1'b0;
              r_m_last       <= 1'b0;
              r_argmax_valid <= 1'b1;
              r_state        <= ST_DONE;
            end else begin
              r_beat   <= r_beat + 1'b1;
              r_m_last <= (r_beat == pBEAT_W'(pBEATS - 2));
            end
          end
        end
        ST_DONE: begin
          r_argmax_valid <= 1'b0;
          r_in_ready     <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_in_ready     <= 1'b1;
          r_m_valid      <= 1'b0;
          r_m_last       <= 1'b0;
          r_argmax_valid <= 1'b0;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign overrun      = r_overrun;
  assign m_data       = w_beat_data;
  assign m_valid      = r_m_valid;
  assign m_last       = r_m_last;
  assign argmax_idx   = r_max_idx;
  assign argmax_val   = r_max_val;
  assign argmax_valid = r_argmax_valid;

endmodule

// File: tb/tb_linear_output_serializer.sv
// tb/tb_linear_output_serializer.sv - self-checking bench for linear_output_serializer
module tb_linear_output_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        m_ready;

  logic        in_ready, overrun, m_valid, m_last, argmax_valid;
  logic [31:0] m_data;
  logic [2:0]  argmax_idx;
  logic [7:0]  argmax_val;

  logic        u_in_ready, u_overrun, u_m_valid, u_m_last, u_argmax_valid;
  logic [31:0] u_m_data;
  logic [2:0]  u_argmax_idx;
  logic [7:0]  u_argmax_val;

  int n_pass  = 0;
  int n_total = 0;
  int cyc_cnt = 0;
  int ovr_seen = 0;
  int last_cap = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;
  always @(negedge clk) if (overrun) ovr_seen++;

  linear_output_serializer #(
    .pDATA_WIDTH(8), .pOUT_FEATURE(8), .pBEAT_ELEMS(4), .pSIGNED(1)
  ) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .overrun(overrun), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .argmax_idx(argmax_idx),
    .argmax_val(argmax_val), .argmax_valid(argmax_valid)
  );

  linear_output_serializer #(
    .pDATA_WIDTH(8), .pOUT_FEATURE(8), .pBEAT_ELEMS(4), .pSIGNED(0)
  ) u_dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(u_in_ready), .overrun(u_overrun), .m_data(u_m_data), .m_valid(u_m_valid),
    .m_ready(m_ready), .m_last(u_m_last), .argmax_idx(u_argmax_idx),
    .argmax_val(u_argmax_val), .argmax_valid(u_argmax_valid)
  );

  typedef struct {
    logic [63:0] vec;
    int          mode;
    logic [2:0]  s_idx;
    logic [7:0]  s_val;
    logic [2:0]  u_idx;
    logic [7:0]  u_val;
  } vec_rec_t;

  vec_rec_t tbl [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Plain linear scan: first index holding the largest value wins.
  function automatic logic [10:0] ref_argmax(input logic [63:0] v, input bit sgn);
    logic [7:0] best;
    logic [7:0] e;
    int bi;
    best = v[7:0];
    bi = 0;
    for (int i = 1; i < 8; i++) begin
      e = v[i*8 +: 8];
      if (sgn ? ($signed(e) > $signed(best)) : (e > best)) begin
        best = e;
        bi = i;
      end
    end
    return {bi[2:0], best};
  endfunction

  // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready
  task automatic stream_vec(input logic [63:0] vec, input int mode, input bit ovr,
                            input logic [2:0] s_idx, input logic [7:0] s_val,
                            input logic [2:0] u_idx, input logic [7:0] u_val, input string tag);
    int hs, cyc, w;
    bit prev_stall;
    logic [31:0] prev_data, exp_beat;
    logic prev_last;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, " in_ready before capture"}, in_ready, 1);
    in_valid = 1'b1;
    in_data  = vec;
    last_cap = cyc_cnt;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, " m_valid at t+1"}, m_valid, 1);
    check({tag, " unsigned m_valid at t+1"}, u_m_valid, 1);
    check({tag, " in_ready low in send"}, in_ready, 0);
    hs = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    while (hs < 2 && cyc < 200) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      if (prev_stall) begin
        check($sformatf("%s stall data stable", tag), m_data, prev_data);
        check($sformatf("%s stall last stable", tag), m_last, prev_last);
      end
      if (ovr && cyc == 0) begin
        in_valid = 1'b1;
        in_data  = ~vec;
      end
      if (ovr && cyc == 1) begin
        in_valid = 1'b0;
        check({tag, " overrun pulse"}, overrun, 1);
        check({tag, " unsigned overrun pulse"}, u_overrun, 1);
      end
      if (m_valid && m_ready) begin
        exp_beat = vec[hs*32 +: 32];
        check($sformatf("%s beat%0d data", tag, hs), m_data, exp_beat);
        check($sformatf("%s beat%0d unsigned data", tag, hs), u_m_data, exp_beat);
        check($sformatf("%s beat%0d last", tag, hs), m_last, (hs == 1));
        check($sformatf("%s beat%0d unsigned last", tag, hs), u_m_last, (hs == 1));
        hs++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(negedge clk);
      cyc++;
    end
    check({tag, " handshake count"}, hs, 2);
    check({tag, " argmax_valid at u+1"}, argmax_valid, 1);
    check({tag, " unsigned argmax_valid at u+1"}, u_argmax_valid, 1);
    check({tag, " argmax_idx"}, argmax_idx, s_idx);
    check({tag, " argmax_val"}, argmax_val, s_val);
    check({tag, " unsigned argmax_idx"}, u_argmax_idx, u_idx);
    check({tag, " unsigned argmax_val"}, u_argmax_val, u_val);
    check({tag, " m_valid low in done"}, m_valid, 0);
    check({tag, " in_ready low in done"}, in_ready, 0);
    check({tag, " overrun quiet in done"}, overrun, 0);
    @(negedge clk);
    check({tag, " argmax_valid single cycle"}, argmax_valid, 0);
    check({tag, " in_ready at u+2"}, in_ready, 1);
    check({tag, " unsigned in_ready at u+2"}, u_in_ready, 1);
    check({tag, " argmax_idx held"}, argmax_idx, s_idx);
    check({tag, " argmax_val held"}, argmax_val, s_val);
  endtask

  initial begin
    int c0, c1, c2, ovr_base, style;
    logic [63:0] rv;
    logic [10:0] rs, ru;
    logic [7:0] pick [4];

    tbl[0] = '{64'h0807060504030201, 0, 3'd7, 8'h08, 3'd7, 8'h08};
    tbl[1] = '{64'h0807060504030201, 1, 3'd7, 8'h08, 3'd7, 8'h08};
    tbl[2] = '{64'h01020500800505FD, 0, 3'd1, 8'h05, 3'd0, 8'hFD};
    tbl[3] = '{64'h0707070707070707, 1, 3'd0, 8'h07, 3'd0, 8'h07};
    tbl[4] = '{64'h01817F007F10FF80, 0, 3'd3, 8'h7F, 3'd1, 8'hFF};
    tbl[5] = '{64'h0409000902010103, 0, 3'd4, 8'h09, 3'd4, 8'h09};
    pick[0] = 8'h80; pick[1] = 8'h7F; pick[2] = 8'hFF; pick[3] = 8'h00;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset m_valid", m_valid, 0);
    check("reset m_last", m_last, 0);
    check("reset m_data", m_data, 0);
    check("reset overrun", overrun, 0);
    check("reset argmax_valid", argmax_valid, 0);
    check("reset argmax_idx", argmax_idx, 0);
    check("reset argmax_val", argmax_val, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++)
      stream_vec(tbl[i].vec, tbl[i].mode, 1'b0, tbl[i].s_idx, tbl[i].s_val,
                 tbl[i].u_idx, tbl[i].u_val, $sformatf("tbl%0d", i));

    stream_vec(tbl[0].vec, 0, 1'b1, 3'd7, 8'h08, 3'd7, 8'h08, "overrun");

    in_valid = 1'b1;
    in_data  = tbl[5].vec;
    @(negedge clk);
    in_valid = 1'b0;
    m_ready  = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst m_valid", m_valid, 0);
    check("midrst in_ready", in_ready, 1);
    check("midrst argmax_valid", argmax_valid, 0);
    check("midrst argmax_idx cleared", argmax_idx, 0);
    @(negedge clk);
    check("midrst no late argmax_valid", argmax_valid, 0);
    check("midrst still idle", m_valid, 0);
    stream_vec(tbl[4].vec, 0, 1'b0, tbl[4].s_idx, tbl[4].s_val, tbl[4].u_idx, tbl[4].u_val, "after_rst");

    rst = 1'b1;
    in_valid = 1'b1;
    in_data = tbl[0].vec;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst+in_valid m_valid", m_valid, 0);
    check("rst+in_valid in_ready", in_ready, 1);
    @(negedge clk);
    check("rst+in_valid stays idle", m_valid, 0);

    ovr_base = ovr_seen;
    stream_vec(tbl[0].vec, 0, 1'b0, tbl[0].s_idx, tbl[0].s_val, tbl[0].u_idx, tbl[0].u_val, "b2b0");
    c0 = last_cap;
    stream_vec(tbl[2].vec, 0, 1'b0, tbl[2].s_idx, tbl[2].s_val, tbl[2].u_idx, tbl[2].u_val, "b2b1");
    c1 = last_cap;
    stream_vec(tbl[5].vec, 0, 1'b0, tbl[5].s_idx, tbl[5].s_val, tbl[5].u_idx, tbl[5].u_val, "b2b2");
    c2 = last_cap;
    check("b2b period 1", c1 - c0, 4);
    check("b2b period 2", c2 - c1, 4);
    check("b2b no overrun", ovr_seen - ovr_base, 0);

    for (int r = 0; r < 25; r++) begin
      style = r % 3;
      for (int b = 0; b < 8; b++) begin
        case (style)
          0: rv[b*8 +: 8] = 8'($urandom);
          1: rv[b*8 +: 8] = 8'($urandom_range(0, 3));
          default: rv[b*8 +: 8] = pick[$urandom_range(0, 3)];
        endcase
      end
      rs = ref_argmax(rv, 1'b1);
      ru = ref_argmax(rv, 1'b0);
      stream_vec(rv, $urandom_range(0, 2), 1'b0, rs[10:8], rs[7:0], ru[10:8], ru[7:0],
                 $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
